display_frame_loader: RTL
=========================

// Module: display_frame_loader
// PURPOSE
//   Assembles the SPI byte stream (from spi_slave) into 24-bit pixels and writes them into the
//   back buffer of display_memory, row-major. On a complete frame it waits for the display
//   driver's safe_flip window, then toggles the buffer-select so the new frame is shown.
//   Sits between spi_slave (upstream) and display_memory / display_driver (downstream).
// PARAMETERS
//   rows     8   panel rows per buffer; RW = $clog2(rows)
//   columns  32  panel columns; CW = $clog2(columns)
//   width    24  pixel width in bits; multiple of 8; NB = width/8 bytes per pixel
// PORTS
//   clk        in   1      single clock (display clock domain)
//   rst        in   1      asynchronous, active-high reset
//   data       in   8      received SPI byte
//   valid      in   1      data valid, one-cycle pulse per byte
//   sot        in   1      start of transfer (ss asserted), one-cycle pulse
//   eot        in   1      end of transfer (ss released), one-cycle pulse
//   safe_flip  in   1      from display_driver: buffer flip allowed this cycle
//   wen        out  1      display_memory write enable
//   wrow       out  RW     write row
//   wcol       out  CW     write column
//   wdata      out  width  write pixel, first byte received in MSBs (R,G,B order)
//   flip       out  1      buffer select level; toggles once per accepted frame
//   busy       out  1      high in LOAD or WAIT_FLIP
//   frame_err  out  1      one-cycle pulse: frame rejected (short or overlong)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; wen=0, wrow=0, wcol=0, wdata=0, flip=0, busy=0,
//     frame_err=0; byte counter, pixel counter, shift register cleared. Mid-frame reset
//     abandons the frame; flip is not toggled.
//   States: IDLE -> LOAD on sot. LOAD -> WAIT_FLIP on eot with exactly rows*columns pixels
//     written and byte counter 0; LOAD -> IDLE on eot otherwise (pulse frame_err).
//     WAIT_FLIP -> IDLE in the cycle safe_flip=1; flip toggles on that edge.
//   Byte assembly (LOAD only): each valid shifts data into shift reg LSBs; on the NB-th byte
//     the cycle after: wen=1 for exactly one cycle, wdata=assembled pixel, wrow/wcol=current
//     write position. Latency: last byte valid at edge N -> wen high during cycle N+1.
//   Addressing: first pixel of a frame at (row 0, col 0); col increments per pixel; col wraps
//     columns-1 -> 0 with row+1. After pixel rows*columns the position saturates (no wrap);
//     further bytes are dropped, no wen, and the frame is flagged overlong (err at eot).
//   sot and valid in same cycle: the byte is the first byte of the new frame.
//   eot and valid in same cycle: byte processed first, then eot evaluated (so the final
//     byte may complete the last pixel in the eot cycle; its wen still issues next cycle).
//   sot while in LOAD: restart frame (counters to 0), pulse frame_err; back buffer content
//     from the aborted frame is simply overwritten.
//   sot/valid/eot while in WAIT_FLIP or eot in IDLE: ignored; no writes, flip unaffected.
//   A rejected frame never toggles flip; front buffer keeps showing the previous frame.
//   wrow/wcol/wdata hold last written values when wen=0.
//   busy is combinational from state (registered state, no extra latency).
// TESTING
//   Full frame: sot, 768 bytes (256 px, pixel k = {k[7:0],8'hA5,~k[7:0]}), eot ->
//     256 wen pulses, pixel 0 at (0,0), pixel 33 at (1,1), pixel 255 at (7,31); safe_flip
//     held 0 for 10 cycles then 1 -> flip 0->1 on that edge, busy falls, frame_err never.
//   Short frame: sot, 600 bytes, eot -> 200 wen pulses, frame_err one cycle, flip stays 0,
//     state IDLE; later safe_flip=1 has no effect.
//   Overlong frame: sot, 771 bytes, eot -> exactly 256 wen, no wen for extra pixel,
//     frame_err pulse, no flip.
//   Edge cases: sot+valid same cycle with byte 0x11 -> pixel 0 wdata[23:16]=0x11; final
//     byte with eot same cycle -> wen for pixel 255 and WAIT_FLIP entered; sot during
//     WAIT_FLIP ignored, flip still toggles once.
//   Restart: sot, 300 bytes, sot, 768 bytes, eot -> frame_err at 2nd sot, second frame
//     written from (0,0), flip toggles after safe_flip.
//   Reset mid-frame: rst asserted asynchronously after 400 bytes -> all outputs 0
//     immediately (before next clk edge), flip=0; subsequent full frame loads correctly.

Source files
------------

// File: rtl/display_frame_loader.sv
// Packs incoming SPI bytes into pixels, writes them row-major into the back buffer,
// and flips the buffer select once a complete frame has landed and the driver allows it.
module display_frame_loader #(
  parameter  int unsigned rows    = 8,
  parameter  int unsigned columns = 32,
  parameter  int unsigned width   = 24,
  localparam int unsigned RW      = $clog2(rows),
  localparam int unsigned CW      = $clog2(columns)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             valid,
  input  logic             sot,
  input  logic             eot,
  input  logic             safe_flip,
  output logic             wen,
  output logic [RW-1:0]    wrow,
  output logic [CW-1:0]    wcol,
  output logic [width-1:0] wdata,
  output logic             flip,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned NB   = width / 8;
  localparam int unsigned NPIX = rows * columns;
  localparam int unsigned PW   = $clog2(NPIX + 1);
  localparam int unsigned BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned SW   = width - 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_FLIP = 2'd2
  } state_e;

  state_e           state_q;
  logic             wen_q, flip_q, err_q, over_q;
  logic [RW-1:0]    wrow_q, row_q, row_base, row_d;
  logic [CW-1:0]    wcol_q, col_q, col_base, col_d;
  logic [width-1:0] wdata_q;
  logic [BW-1:0]    bcnt_q, bcnt_base, bcnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_base, pcnt_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             over_base, over_d;
  logic             start_c, in_frame_c, full_c, take_c, last_c, frame_ok_c;

  // Frame bookkeeping after an optional restart, with the current byte applied first
  always_comb begin
    start_c    = sot && (state_q != WAIT_FLIP);
    in_frame_c = start_c || (state_q == LOAD);
    bcnt_base  = start_c ? '0 : bcnt_q;
    pcnt_base  = start_c ? '0 : pcnt_q;
    row_base   = start_c ? '0 : row_q;
    col_base   = start_c ? '0 : col_q;
    over_base  = start_c ? 1'b0 : over_q;
    full_c     = (pcnt_base == PW'(NPIX));
    take_c     = in_frame_c && valid && !full_c;
    last_c     = take_c && (bcnt_base == BW'(NB - 1));
    shift_d    = shift_q;
    bcnt_d     = bcnt_base;
    pcnt_d     = pcnt_base;
    row_d      = row_base;
    col_d      = col_base;
    if (take_c) begin
      shift_d = {shift_q[SW-9:0], data};
      bcnt_d  = last_c ? '0 : bcnt_base + 1'b1;
    end
    if (last_c) begin
      pcnt_d = pcnt_base + 1'b1;
      // Position saturates on the final pixel of the panel
      if (pcnt_base != PW'(NPIX - 1)) begin
        if (col_base == CW'(columns - 1)) begin
          col_d = '0;
          row_d = row_base + 1'b1;
        end else begin
          col_d = col_base + 1'b1;
        end
      end
    end
    over_d     = over_base || (in_frame_c && valid && full_c);
    frame_ok_c = (pcnt_d == PW'(NPIX)) && (bcnt_d == '0) && !over_d;
  end

  // Frame FSM, memory write port and flip register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      wdata_q <= '0;
      flip_q  <= 1'b0;
      err_q   <= 1'b0;
      bcnt_q  <= '0;
      pcnt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      over_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      wen_q <= 1'b0;
      err_q <= 1'b0;
      if (in_frame_c) begin
        bcnt_q  <= bcnt_d;
        pcnt_q  <= pcnt_d;
        row_q   <= row_d;
        col_q   <= col_d;
        over_q  <= over_d;
        shift_q <= shift_d;
      end
      if (last_c) begin
        wen_q   <= 1'b1;
        wdata_q <= {shift_q, data};
        wrow_q  <= row_base;
        wcol_q  <= col_base;
      end
      case (state_q)
        IDLE: begin
          if (sot) state_q <= LOAD;
        end
        LOAD: begin
          if (sot) begin
            err_q <= 1'b1;
          end else if (eot) begin
            if (frame_ok_c) begin
              state_q <= WAIT_FLIP;
            end else begin
              state_q <= IDLE;
              err_q   <= 1'b1;
            end
          end
        end
        WAIT_FLIP: begin
          if (safe_flip) begin
            flip_q  <= ~flip_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wen       = wen_q;
  assign wrow      = wrow_q;
  assign wcol      = wcol_q;
  assign wdata     = wdata_q;
  assign flip      = flip_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule
